j_dsp_run_seq: RTL and testbench
================================

# j_dsp_run_seq

Run/single-step sequencer for the Jerry DSP instruction stream. It sits between the DSP control register (go, single_step, single_go, bus_hog) and the DSP fetch/issue pipeline. It requests instruction fetches, issues each fetched instruction to the pipeline, and halts after one instruction when single-stepping. It also drives the single_stop status bit, and throttles fetches when bus_hog is clear so that other bus masters get bus slots.

## Interface
Parameters:
- FETCH_GAP, default 2: idle cycles inserted between consecutive fetches while bus_hog=0. Range 0–15.

Ports:
- clk, in, 1: system clock; sole clock of the block.
- reset, in, 1: synchronous, active-high reset.
- go, in, 1: run enable, level, from control register.
- single_step, in, 1: single-step mode, level.
- single_go, in, 1: one-cycle pulse; advances one instruction while stopped.
- bus_hog, in, 1: 1 = fetch back-to-back, no gap.
- ifetch_req, out, 1: instruction fetch request.
- ifetch_ack, in, 1: fetch complete; one-cycle pulse.
- pipe_busy, in, 1: pipeline cannot accept an issue this cycle.
- issue, out, 1: one-cycle pulse that launches the fetched instruction.
- exec_done, in, 1: one-cycle pulse when the issued instruction retires.
- single_stop, out, 1: DSP is halted in single-step; status bit 3.

## Operation
- States: IDLE, FETCH, ISSUE, GAP, WAIT_DONE, STOPPED. Reset state is IDLE.
- Reset values: ifetch_req=0, issue=0, single_stop=0, gap counter=0.
- Output decode:
  - ifetch_req = (state==FETCH).
  - issue = (state==ISSUE) & go & ~pipe_busy.
  - single_stop = (state==STOPPED).
- IDLE: go=1 → FETCH.
- FETCH: ifetch_req held high until ifetch_ack; it never drops mid-handshake, even if go falls. On ack:
  - go=1 → ISSUE.
  - go=0 → IDLE; the fetched word is discarded.
- ISSUE:
  - go=0 → IDLE with no issue.
  - pipe_busy=1 → stay in ISSUE.
  - Otherwise issue pulses; then:
    - single_step=1 → WAIT_DONE.
    - else bus_hog=0 and FETCH_GAP>0 → GAP, counter loaded with FETCH_GAP-1.
    - else → FETCH.
- GAP: counter decrements each cycle; at 0 → FETCH. go=0 → IDLE.
- WAIT_DONE:
  - exec_done → STOPPED.
  - go=0 → IDLE; this has priority over a simultaneous exec_done.
- STOPPED:
  - go=0 → IDLE.
  - single_step=0 → FETCH (resume free run).
  - single_go=1 → FETCH (one more instruction).
- single_go outside STOPPED is ignored and not remembered.
- A single_step change takes effect at the next issue decision; an in-flight fetch completes normally.
- bus_hog is sampled at the issue cycle only.
- Reset mid-operation → IDLE next edge; ifetch_req drops immediately. The fetch unit is reset by the same reset.

## Timing
- Free run, bus_hog=1, zero-wait fetch (ack in the first FETCH cycle): fetch cycle n, issue n+1, next ifetch_req n+2. One instruction per 2 cycles.
- bus_hog=0: FETCH_GAP extra cycles between issue and the next ifetch_req.
- go rising at edge k → ifetch_req high from k+1.
- ifetch_ack at cycle m with pipe_busy=0 → issue in cycle m+1.
- exec_done at cycle d in WAIT_DONE → single_stop=1 from d+1.
- single_go at cycle s while stopped → single_stop=0 and ifetch_req=1 from s+1.
- All state changes occur on the rising clk edge; no combinational path from ifetch_ack or exec_done to outputs.

## Structure
- Shared package j_dsp_pkg holds:
  - the state enum (3-bit encoding);
  - the localparam for gap counter width (4).
- One sub-module: j_dsp_gap_cnt, a loadable 4-bit down-counter with load, enable and zero flag, synchronous active-high reset.
- Remainder: FSM and output decode in j_dsp_run_seq.

## Test plan
- Free run, FETCH_GAP=2: go=1, bus_hog=1, ack 1 cycle after each req, pipe_busy=0 → issue every 2 cycles. Then set bus_hog=0 → issue every 4 cycles.
- Single step: single_step=1, go=1 → exactly one issue; exec_done 3 cycles later → single_stop=1 the next cycle. Three single_go pulses → three further issues, each followed by STOPPED after exec_done.
- Stall: pipe_busy=1 for 5 cycles after ack → issue held off, then a single pulse on the cycle pipe_busy=0. Never more than one issue per fetch.
- go drop in FETCH: go=0 while ifetch_req=1, ack 3 cycles later → req stays high until ack, no issue, IDLE after ack.
- Races:
  - exec_done and go=0 in the same cycle → IDLE, single_stop stays 0.
  - single_go while in FETCH → ignored; no extra instruction.
- Reset mid-fetch: reset=1 with ifetch_req=1 → next cycle all outputs 0 and state IDLE. Release with go=1 → ifetch_req 1 cycle after reset deasserts.

Source files
------------

// File: rtl/j_dsp_pkg.sv
// j_dsp_pkg: shared state encoding and gap counter width for the DSP run sequencer
package j_dsp_pkg;
    localparam int GAP_W = 4;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        GAP       = 3'd3,
        WAIT_DONE = 3'd4,
        STOPPED   = 3'd5
    } state_t;
endpackage

// File: rtl/j_dsp_gap_cnt.sv
// j_dsp_gap_cnt: loadable down-counter with zero flag for inter-fetch gaps
module j_dsp_gap_cnt
    import j_dsp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [GAP_W-1:0] load_val,
    output logic             zero
);
    logic [GAP_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/j_dsp_run_seq.sv
// j_dsp_run_seq: run/single-step sequencer driving DSP instruction fetch and issue
module j_dsp_run_seq
    import j_dsp_pkg::*;
#(
    parameter int FETCH_GAP = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic single_step,
    input  logic single_go,
    input  logic bus_hog,
    output logic ifetch_req,
    input  logic ifetch_ack,
    input  logic pipe_busy,
    output logic issue,
    input  logic exec_done,
    output logic single_stop
);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((FETCH_GAP > 0) ? FETCH_GAP - 1 : 0);
    localparam logic HAS_GAP = (FETCH_GAP > 0);
    state_t state, state_nxt;
    logic cnt_load, cnt_en, cnt_zero;
    j_dsp_gap_cnt u_gap_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .en      (cnt_en),
        .load_val(GAP_LOAD),
        .zero    (cnt_zero)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE:      state_nxt = go ? FETCH : IDLE;
            FETCH:     if (ifetch_ack) state_nxt = go ? ISSUE : IDLE;
            ISSUE: begin
                if (!go) state_nxt = IDLE;
                else if (!pipe_busy) begin
                    if (single_step) state_nxt = WAIT_DONE;
                    else if (!bus_hog && HAS_GAP) begin
                        state_nxt = GAP;
                        cnt_load  = 1'b1;
                    end else state_nxt = FETCH;
                end
            end
            GAP: begin
                if (!go) state_nxt = IDLE;
                else if (cnt_zero) state_nxt = FETCH;
                else cnt_en = 1'b1;
            end
            // go falling wins over a coincident exec_done
            WAIT_DONE: state_nxt = !go ? IDLE : (exec_done ? STOPPED : WAIT_DONE);
            STOPPED:   state_nxt = !go ? IDLE : ((!single_step || single_go) ? FETCH : STOPPED);
            default:   state_nxt = IDLE;
        endcase
    end
    assign ifetch_req  = (state == FETCH);
    assign issue       = (state == ISSUE) && go && !pipe_busy;
    assign single_stop = (state == STOPPED);
endmodule

// File: tb/tb_j_dsp_run_seq.sv
// tb_j_dsp_run_seq: directed-vector bench for the DSP run/single-step sequencer
module tb_j_dsp_run_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0, single_step = 1'b0, single_go = 1'b0, bus_hog = 1'b1;
    logic pipe_busy = 1'b0, exec_done = 1'b0;
    logic auto_ack = 1'b0, man_ack = 1'b0;
    logic ifetch_req, ifetch_ack, issue, single_stop;
    int checks = 0, errors = 0;
    int issue_cnt = 0;
    always #5 clk = ~clk;
    // zero-wait fetch unit: acks in the first cycle the request is seen
    assign ifetch_ack = man_ack | (auto_ack & ifetch_req);
    always @(posedge clk) if (issue) issue_cnt <= issue_cnt + 1;
    j_dsp_run_seq #(.FETCH_GAP(2)) dut (
        .clk(clk), .reset(reset), .go(go), .single_step(single_step),
        .single_go(single_go), .bus_hog(bus_hog), .ifetch_req(ifetch_req),
        .ifetch_ack(ifetch_ack), .pipe_busy(pipe_busy), .issue(issue),
        .exec_done(exec_done), .single_stop(single_stop)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1; go = 1'b0; single_step = 1'b0; single_go = 1'b0; bus_hog = 1'b1;
        pipe_busy = 1'b0; exec_done = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask
    task automatic test_reset();
        step(); step();
        checks++; if (ifetch_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ifetch_req); end
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b want 0", issue); end
        checks++; if (single_stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b want 0", single_stop); end
        reset = 1'b0;
    endtask
    task automatic test_free_run();
        do_reset();
        auto_ack = 1'b1; go = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (ifetch_req !== (i % 2 == 0)) begin errors++; $display("FAIL hog_req[%0d]: got %b want %b", i, ifetch_req, i % 2 == 0); end
            checks++; if (issue !== (i % 2 == 1)) begin errors++; $display("FAIL hog_issue[%0d]: got %b want %b", i, issue, i % 2 == 1); end
        end
        step();
        bus_hog = 1'b0;
        for (int j = 0; j < 9; j++) begin
            step();
            checks++; if (issue !== (j % 4 == 0)) begin errors++; $display("FAIL gap_issue[%0d]: got %b want %b", j, issue, j % 4 == 0); end
            checks++; if (ifetch_req !== (j % 4 == 3)) begin errors++; $display("FAIL gap_req[%0d]: got %b want %b", j, ifetch_req, j % 4 == 3); end
        end
    endtask
    task automatic test_single_step();
        int base;
        do_reset();
        auto_ack = 1'b1; single_step = 1'b1; go = 1'b1;
        base = issue_cnt;
        step();
        step();
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL ss_first_issue: got %b want 1", issue); end
        step(); step();
        checks++; if (single_stop !== 1'b0 || ifetch_req !== 1'b0) begin errors++; $display("FAIL ss_wait: stop=%b req=%b want 0 0", single_stop, ifetch_req); end
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        checks++; if (single_stop !== 1'b1) begin errors++; $display("FAIL ss_stop: got %b want 1", single_stop); end
        step(); step(); step();
        checks++; if (single_stop !== 1'b1 || ifetch_req !== 1'b0) begin errors++; $display("FAIL ss_hold: stop=%b req=%b want 1 0", single_stop, ifetch_req); end
        for (int k = 0; k < 3; k++) begin
            single_go = 1'b1;
            step();
            single_go = 1'b0;
            checks++; if (single_stop !== 1'b0 || ifetch_req !== 1'b1) begin errors++; $display("FAIL sg_go[%0d]: stop=%b req=%b want 0 1", k, single_stop, ifetch_req); end
            step();
            checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sg_issue[%0d]: got %b want 1", k, issue); end
            step();
            exec_done = 1'b1;
            step();
            exec_done = 1'b0;
            checks++; if (single_stop !== 1'b1) begin errors++; $display("FAIL sg_stop[%0d]: got %b want 1", k, single_stop); end
        end
        checks++; if (issue_cnt - base !== 4) begin errors++; $display("FAIL ss_count: got %0d want 4", issue_cnt - base); end
    endtask
    task automatic test_stall();
        int base;
        do_reset();
        go = 1'b1;
        base = issue_cnt;
        step();
        pipe_busy = 1'b1; man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (issue !== 1'b0) begin errors++; $display("FAIL stall_issue[%0d]: got %b want 0", i, issue); end
            if (i < 4) step();
        end
        pipe_busy = 1'b0;
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", issue); end
        step();
        checks++; if (issue !== 1'b0 || ifetch_req !== 1'b1) begin errors++; $display("FAIL stall_after: issue=%b req=%b want 0 1", issue, ifetch_req); end
        step(); step();
        checks++; if (issue_cnt - base !== 1) begin errors++; $display("FAIL stall_count: got %0d want 1", issue_cnt - base); end
    endtask
    task automatic test_go_drop();
        int base;
        do_reset();
        go = 1'b1;
        base = issue_cnt;
        step();
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ifetch_req !== 1'b1) begin errors++; $display("FAIL drop_req[%0d]: got %b want 1", i, ifetch_req); end
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        checks++; if (ifetch_req !== 1'b0 || issue !== 1'b0) begin errors++; $display("FAIL drop_idle: req=%b issue=%b want 0 0", ifetch_req, issue); end
        step(); step();
        checks++; if (issue_cnt - base !== 0 || ifetch_req !== 1'b0) begin errors++; $display("FAIL drop_count: issues=%0d req=%b want 0 0", issue_cnt - base, ifetch_req); end
    endtask
    task automatic test_races();
        int base;
        do_reset();
        auto_ack = 1'b1; single_step = 1'b1; go = 1'b1;
        step(); step(); step();
        exec_done = 1'b1; go = 1'b0;
        step();
        exec_done = 1'b0;
        checks++; if (single_stop !== 1'b0 || ifetch_req !== 1'b0) begin errors++; $display("FAIL race_done_go: stop=%b req=%b want 0 0", single_stop, ifetch_req); end
        step();
        checks++; if (single_stop !== 1'b0) begin errors++; $display("FAIL race_done_go_hold: got %b want 0", single_stop); end
        do_reset();
        single_step = 1'b1; go = 1'b1;
        base = issue_cnt;
        step();
        single_go = 1'b1;
        step();
        single_go = 1'b0; man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL race_sg_issue: got %b want 1", issue); end
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        checks++; if (single_stop !== 1'b1) begin errors++; $display("FAIL race_sg_stop: got %b want 1", single_stop); end
        step(); step(); step();
        checks++; if (single_stop !== 1'b1 || ifetch_req !== 1'b0 || issue_cnt - base !== 1) begin errors++; $display("FAIL race_sg_ignored: stop=%b req=%b issues=%0d want 1 0 1", single_stop, ifetch_req, issue_cnt - base); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        go = 1'b1;
        step();
        checks++; if (ifetch_req !== 1'b1) begin errors++; $display("FAIL mid_req_before: got %b want 1", ifetch_req); end
        reset = 1'b1;
        step();
        checks++; if (ifetch_req !== 1'b0 || issue !== 1'b0 || single_stop !== 1'b0) begin errors++; $display("FAIL mid_reset: req=%b issue=%b stop=%b want 0 0 0", ifetch_req, issue, single_stop); end
        reset = 1'b0;
        step();
        checks++; if (ifetch_req !== 1'b1) begin errors++; $display("FAIL mid_restart: got %b want 1", ifetch_req); end
        go = 1'b0;
    endtask
    initial begin
        test_reset();
        test_free_run();
        test_single_step();
        test_stall();
        test_go_drop();
        test_races();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
